reaction_timer_ctrl: RTL and testbench
======================================

Name: reaction_timer_ctrl

Overview:
Top-level sequencer for the reaction-timer game.
- Arms the random-delay counter and enables the reaction-time counter.
- Enables the error counter when the player presses early, via its error_wait / error_wait_done pair.
- Latches the result and selects what the display shows.
- Sits between the debounced buttons and the counter/display datapath. All outputs are registered (Moore).

Parameters:
MAX_TIME, 9999, reaction count (ms) at which the attempt times out.
TW, 14, width of time_ms and result.

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
start  input  1  debounced start button level
stop  input  1  debounced reaction button level
rwait_done  input  1  random-delay counter expired (level or pulse)
error_wait_done  input  1  error counter finished its penalty interval
time_ms  input  TW  running reaction count from the time counter
rwait_start  output  1  one-cycle pulse: load/start the random-delay counter
time_clr  output  1  one-cycle pulse: clear the reaction counter
time_en  output  1  reaction counter count enable
error_wait  output  1  error counter enable, held high for the whole penalty interval
led  output  1  "press now" stimulus LED
disp_sel  output  2  00 blank, 01 result, 10 "Err", 11 timeout
result  output  TW  latched reaction time
busy  output  1  high in every state except IDLE and SHOW

Behaviour:
- Edge detection:
  - Internal previous-value registers on start and stop.
  - start_re = start & ~start_q; stop_re = stop & ~stop_q.
  - Both previous-value registers clear on reset.
- Reset (synchronous): state IDLE; every output 0; result 0; disp_sel 00.
- IDLE: on start_re -> ARM; otherwise stay.
- ARM (exactly 1 cycle): rwait_start=1, time_clr=1, disp_sel=00. Next state WAIT.
- WAIT:
  - stop_re -> ERROR.
  - else rwait_done -> TIMING.
  - stop_re and rwait_done in the same cycle -> ERROR (early press wins).
- TIMING:
  - led=1, time_en=1.
  - stop_re -> SHOW, with result <= min(time_ms, MAX_TIME).
  - else time_ms >= MAX_TIME -> TIMEOUT, with result <= MAX_TIME.
  - Both in the same cycle -> SHOW.
- SHOW: disp_sel=01, led=0, time_en=0. On start_re -> ARM (new attempt).
- ERROR:
  - error_wait=1 from the first ERROR cycle until error_wait_done is sampled high; disp_sel=10.
  - On error_wait_done -> IDLE. disp_sel stays 10 and result stays unchanged until the next ARM.
- TIMEOUT: disp_sel=11, time_en=0. On start_re -> ARM.
- Ignored inputs:
  - start_re in WAIT, TIMING, ERROR.
  - stop_re in IDLE, SHOW, TIMEOUT, ARM.
- Output timing: outputs are the registered decode of the next state, so they are valid in the cycle the state is entered. Latency from start_re to the rwait_start pulse is 1 clk.
- Reset mid-operation: on the next clk edge, state is IDLE and all outputs are 0 (time_en and error_wait drop, led off).
- Width rules:
  - time_ms is compared unsigned against MAX_TIME.
  - result is TW bits and is never larger than MAX_TIME.

Decomposition:
- Shared package reaction_pkg:
  - typedef enum logic [2:0] state_t {IDLE, ARM, WAIT, TIMING, SHOW, ERROR, TIMEOUT}.
  - disp_sel constants DISP_BLANK, DISP_TIME, DISP_ERR, DISP_TO.
  - localparam TW.
- One natural sub-module, edge_det: a 1-bit rising-edge detector with synchronous reset, instantiated twice (start, stop).

Test Plan:
- Normal attempt:
  - Stimulus: reset 1 cycle; start rise; rwait_done high 20 clks later; stop rise when time_ms=245.
  - Required response: rwait_start and time_clr pulse 1 clk after start; led=1 and time_en=1 from the clk after rwait_done; then SHOW with result=245, disp_sel=01, led=0.
- Early press:
  - Stimulus: stop rise in WAIT; error_wait_done asserted 10 clks later.
  - Required response: error_wait=1 for exactly those 10 clks; disp_sel=10; then IDLE with error_wait=0.
- Tie:
  - Stimulus: stop rise and rwait_done in the same cycle.
  - Required response: ERROR entered; led never asserts.
- Timeout:
  - Stimulus: in TIMING, drive time_ms=9999 with no stop.
  - Required response: TIMEOUT; result=9999; disp_sel=11; time_en=0.
- Ignore and held buttons:
  - Stimulus: start rise during TIMING; stop held high continuously through WAIT into TIMING.
  - Required response: no state change (no re-arm, no ERROR from the held level); only a fresh stop rise stops timing.
- Reset mid-TIMING:
  - Stimulus: assert reset with time_en=1.
  - Required response: the next edge gives IDLE with all outputs 0; a subsequent start rise gives a normal ARM.

Source files
------------

// File: rtl/reaction_pkg.sv
// Shared types and constants for the reaction-timer sequencer.
// Provides the FSM state encoding, display-select codes and count width.
package reaction_pkg;

    localparam int TW = 14;
    localparam int MAX_TIME_DEF = 9999;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        WAIT,
        TIMING,
        SHOW,
        ERROR,
        TIMEOUT
    } state_t;

    localparam logic [1:0] DISP_BLANK = 2'b00;
    localparam logic [1:0] DISP_TIME  = 2'b01;
    localparam logic [1:0] DISP_ERR   = 2'b10;
    localparam logic [1:0] DISP_TO    = 2'b11;

endpackage

// File: rtl/reaction_timer_ctrl_edge_det.sv
// 1-bit rising-edge detector with synchronous active-high reset.
// Ports: clk, reset, d_i (level in), rise_o (d_i high now, low last cycle).
module edge_det (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic rise_o
);

    logic d_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            d_q <= 1'b0;
        end else begin
            d_q <= d_i;
        end
    end

    assign rise_o = d_i & ~d_q;

endmodule

// File: rtl/reaction_timer_ctrl.sv
// Top-level sequencer for the reaction-timer game (Moore, registered outputs).
// Inputs: start/stop buttons, rwait_done, error_wait_done, time_ms.
// Outputs: rwait_start, time_clr, time_en, error_wait, led, disp_sel, result, busy.
module reaction_timer_ctrl #(
    parameter int MAX_TIME = 9999,
    parameter int TW       = 14
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          stop,
    input  logic          rwait_done,
    input  logic          error_wait_done,
    input  logic [TW-1:0] time_ms,
    output logic          rwait_start,
    output logic          time_clr,
    output logic          time_en,
    output logic          error_wait,
    output logic          led,
    output logic [1:0]    disp_sel,
    output logic [TW-1:0] result,
    output logic          busy
);

    import reaction_pkg::*;

    localparam logic [TW-1:0] MAX_T = TW'(MAX_TIME);

    logic start_re;
    logic stop_re;

    state_t        state_q, state_d;
    logic [TW-1:0] result_q, result_d;
    logic [1:0]    disp_q, disp_d;
    logic          rwait_start_q, rwait_start_d;
    logic          time_clr_q, time_clr_d;
    logic          time_en_q, time_en_d;
    logic          error_wait_q, error_wait_d;
    logic          led_q, led_d;
    logic          busy_q, busy_d;

    edge_det u_start_ed (
        .clk    (clk),
        .reset  (reset),
        .d_i    (start),
        .rise_o (start_re)
    );

    edge_det u_stop_ed (
        .clk    (clk),
        .reset  (reset),
        .d_i    (stop),
        .rise_o (stop_re)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            result_q      <= '0;
            disp_q        <= DISP_BLANK;
            rwait_start_q <= 1'b0;
            time_clr_q    <= 1'b0;
            time_en_q     <= 1'b0;
            error_wait_q  <= 1'b0;
            led_q         <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            result_q      <= result_d;
            disp_q        <= disp_d;
            rwait_start_q <= rwait_start_d;
            time_clr_q    <= time_clr_d;
            time_en_q     <= time_en_d;
            error_wait_q  <= error_wait_d;
            led_q         <= led_d;
            busy_q        <= busy_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        unique case (state_q)
            IDLE: begin
                if (start_re) state_d = ARM;
            end
            ARM: begin
                state_d = WAIT;
            end
            WAIT: begin
                // An early press beats a simultaneous delay expiry.
                if (stop_re) begin
                    state_d = ERROR;
                end else if (rwait_done) begin
                    state_d = TIMING;
                end
            end
            TIMING: begin
                if (stop_re) begin
                    state_d  = SHOW;
                    result_d = (time_ms > MAX_T) ? MAX_T : time_ms;
                end else if (time_ms >= MAX_T) begin
                    state_d  = TIMEOUT;
                    result_d = MAX_T;
                end
            end
            SHOW, TIMEOUT: begin
                if (start_re) state_d = ARM;
            end
            ERROR: begin
                if (error_wait_done) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs decode the next state so they align with state entry.
    always_comb begin
        disp_d        = disp_q;
        rwait_start_d = (state_d == ARM);
        time_clr_d    = (state_d == ARM);
        time_en_d     = (state_d == TIMING);
        led_d         = (state_d == TIMING);
        error_wait_d  = (state_d == ERROR);
        busy_d        = (state_d != IDLE) && (state_d != SHOW);
        unique case (state_d)
            ARM:     disp_d = DISP_BLANK;
            SHOW:    disp_d = DISP_TIME;
            ERROR:   disp_d = DISP_ERR;
            TIMEOUT: disp_d = DISP_TO;
            default: disp_d = disp_q;
        endcase
    end

    assign rwait_start = rwait_start_q;
    assign time_clr    = time_clr_q;
    assign time_en     = time_en_q;
    assign error_wait  = error_wait_q;
    assign led         = led_q;
    assign disp_sel    = disp_q;
    assign result      = result_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_reaction_timer_ctrl.sv
// Directed self-checking bench for reaction_timer_ctrl.
// Drives inputs 1ns after each rising edge and checks outputs at that point.
module tb_reaction_timer_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        rwait_done = 1'b0;
    logic        error_wait_done = 1'b0;
    logic [13:0] time_ms = '0;
    logic        rwait_start;
    logic        time_clr;
    logic        time_en;
    logic        error_wait;
    logic        led;
    logic [1:0]  disp_sel;
    logic [13:0] result;
    logic        busy;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    reaction_timer_ctrl #(.MAX_TIME(9999), .TW(14)) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .stop            (stop),
        .rwait_done      (rwait_done),
        .error_wait_done (error_wait_done),
        .time_ms         (time_ms),
        .rwait_start     (rwait_start),
        .time_clr        (time_clr),
        .time_en         (time_en),
        .error_wait      (error_wait),
        .led             (led),
        .disp_sel        (disp_sel),
        .result          (result),
        .busy            (busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Flag order: rwait_start time_clr time_en error_wait led busy disp_sel[1:0]
    task automatic chk_o(input string tag, input logic [7:0] exp);
        logic [7:0] obs;
        obs = {rwait_start, time_clr, time_en, error_wait, led, busy, disp_sel};
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s outputs observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_r(input string tag, input logic [13:0] exp);
        checks++;
        assert (result === exp) else begin
            failures++;
            $error("FAIL %s result observed=%0d expected=%0d", tag, result, exp);
        end
    endtask

    initial begin
        // Reset
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk_o("reset", 8'b000000_00);
        chk_r("reset_res", 14'd0);

        // Normal attempt
        start = 1'b1;
        step();
        chk_o("arm", 8'b110001_00);
        start = 1'b0;
        step();
        chk_o("wait", 8'b000001_00);
        for (int i = 0; i < 18; i++) step();
        chk_o("wait_long", 8'b000001_00);
        rwait_done = 1'b1;
        step();
        chk_o("timing", 8'b001011_00);
        rwait_done = 1'b0;
        time_ms = 14'd245;
        stop = 1'b1;
        step();
        chk_o("show", 8'b000000_01);
        chk_r("show_res", 14'd245);
        stop = 1'b0;

        // Early press
        start = 1'b1;
        step();
        chk_o("arm2", 8'b110001_00);
        start = 1'b0;
        step();
        stop = 1'b1;
        step();
        chk_o("error", 8'b000101_10);
        stop = 1'b0;
        for (int i = 0; i < 9; i++) step();
        chk_o("error_held", 8'b000101_10);
        error_wait_done = 1'b1;
        step();
        error_wait_done = 1'b0;
        chk_o("err_idle", 8'b000000_10);
        chk_r("err_res", 14'd245);

        // Tie: stop rise with rwait_done
        start = 1'b1;
        step();
        chk_o("arm3", 8'b110001_00);
        start = 1'b0;
        step();
        stop = 1'b1;
        rwait_done = 1'b1;
        step();
        chk_o("tie", 8'b000101_10);
        stop = 1'b0;
        rwait_done = 1'b0;
        step();
        chk_o("tie_hold", 8'b000101_10);
        error_wait_done = 1'b1;
        step();
        error_wait_done = 1'b0;
        chk_o("tie_idle", 8'b000000_10);

        // Held stop, ignored start, then timeout
        time_ms = 14'd0;
        start = 1'b1;
        step();
        start = 1'b0;
        stop = 1'b1;
        step();
        chk_o("held_wait", 8'b000001_00);
        step();
        chk_o("held_wait2", 8'b000001_00);
        rwait_done = 1'b1;
        step();
        rwait_done = 1'b0;
        chk_o("held_timing", 8'b001011_00);
        step();
        chk_o("held_timing2", 8'b001011_00);
        start = 1'b1;
        step();
        start = 1'b0;
        chk_o("start_ignored", 8'b001011_00);
        time_ms = 14'd9999;
        step();
        chk_o("timeout", 8'b000001_11);
        chk_r("timeout_res", 14'd9999);
        stop = 1'b0;
        step();
        chk_o("timeout_hold", 8'b000001_11);

        // Stop with time_ms above MAX_TIME saturates
        time_ms = 14'd0;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        rwait_done = 1'b1;
        step();
        rwait_done = 1'b0;
        time_ms = 14'd12000;
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk_o("sat_show", 8'b000000_01);
        chk_r("sat_res", 14'd9999);

        // Reset mid-TIMING
        time_ms = 14'd0;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        rwait_done = 1'b1;
        step();
        rwait_done = 1'b0;
        time_ms = 14'd9998;
        step();
        chk_o("below_max", 8'b001011_00);
        reset = 1'b1;
        step();
        chk_o("mid_reset", 8'b000000_00);
        chk_r("mid_reset_res", 14'd0);
        reset = 1'b0;
        time_ms = 14'd0;
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        chk_o("rearm", 8'b110001_00);
        step();
        chk_o("rearm_wait", 8'b000001_00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
